// File: rtl/device1_tx.sv
// Two-lane serial byte transmitter: each lane queues bytes in a 4-deep FIFO and
// shifts them out MSB first, preceded by a sync preamble of idle symbols after reset.

module device1_tx_lane #(
    parameter logic [7:0] IDLE         = 8'hBC,
    parameter int         SYNC_SYMBOLS = 4,
    parameter int         AF_TH        = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] data_in,
    output logic       out,
    output logic       active,
    output logic       almost_full,
    output logic       full,
    output logic       push_err
);

    localparam int SW = $clog2(SYNC_SYMBOLS + 1);

    typedef enum logic {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    logic [7:0]    r_mem [4];
    logic [1:0]    r_wr_ptr;
    logic [1:0]    r_rd_ptr;
    logic [2:0]    r_occ;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit_cnt;
    logic [SW-1:0] r_sync_cnt;
    state_t        r_state;
    logic          r_push_err;

    logic w_full;
    logic w_empty;
    logic w_boundary;
    logic w_last_sync;
    logic w_take_data;
    logic w_pop;
    logic w_push_ok;

    // Full/empty come from the pre-edge occupancy, so a pop on the same edge
    // never makes room for a push that arrives while full.
    assign w_full      = (r_occ == 3'd4);
    assign w_empty     = (r_occ == 3'd0);
    assign w_boundary  = (r_bit_cnt == 3'd7);
    assign w_last_sync = (r_sync_cnt == SW'(SYNC_SYMBOLS - 1));
    assign w_take_data = w_boundary && ((r_state == ST_ACTIVE) || w_last_sync);
    assign w_pop       = w_take_data && !w_empty;
    assign w_push_ok   = push && !w_full && (data_in != IDLE);

    // Storage is left unreset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift    <= IDLE;
            r_bit_cnt  <= 3'd0;
            r_sync_cnt <= '0;
            r_state    <= ST_SYNC;
            r_wr_ptr   <= 2'd0;
            r_rd_ptr   <= 2'd0;
            r_occ      <= 3'd0;
            r_push_err <= 1'b0;
        end else begin
            if (w_boundary) begin
                r_bit_cnt <= 3'd0;
                if (r_state == ST_SYNC) begin
                    r_sync_cnt <= r_sync_cnt + 1'b1;
                    if (w_last_sync) begin
                        r_state <= ST_ACTIVE;
                    end
                end
                if (w_pop) begin
                    r_shift <= r_mem[r_rd_ptr];
                end else begin
                    r_shift <= IDLE;
                end
            end else begin
                r_shift   <= {r_shift[6:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_occ <= r_occ + 3'd1;
                2'b01:   r_occ <= r_occ - 3'd1;
                default: r_occ <= r_occ;
            endcase

            r_push_err <= push && !w_push_ok;
        end
    end

    assign out         = r_shift[7];
    assign active      = (r_state == ST_ACTIVE);
    assign almost_full = (r_occ >= 3'(AF_TH));
    assign full        = w_full;
    assign push_err    = r_push_err;

endmodule

module device1_tx #(
    parameter logic [7:0] IDLE         = 8'hBC,
    parameter int         SYNC_SYMBOLS = 4,
    parameter int         AF_TH        = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push0,
    input  logic       push1,
    input  logic [7:0] data_in0,
    input  logic [7:0] data_in1,
    output logic       out0,
    output logic       out1,
    output logic       active0,
    output logic       active1,
    output logic       almost_full0,
    output logic       almost_full1,
    output logic       full0,
    output logic       full1,
    output logic       push_err0,
    output logic       push_err1
);

    logic [1:0] w_push;
    logic [7:0] w_data [2];
    logic [1:0] w_out;
    logic [1:0] w_active;
    logic [1:0] w_almost_full;
    logic [1:0] w_full;
    logic [1:0] w_push_err;

    assign w_push    = {push1, push0};
    assign w_data[0] = data_in0;
    assign w_data[1] = data_in1;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            device1_tx_lane #(
                .IDLE         (IDLE),
                .SYNC_SYMBOLS (SYNC_SYMBOLS),
                .AF_TH        (AF_TH)
            ) u_lane (
                .clk         (clk),
                .reset       (reset),
                .push        (w_push[gi]),
                .data_in     (w_data[gi]),
                .out         (w_out[gi]),
                .active      (w_active[gi]),
                .almost_full (w_almost_full[gi]),
                .full        (w_full[gi]),
                .push_err    (w_push_err[gi])
            );
        end
    endgenerate

    assign out0         = w_out[0];
    assign out1         = w_out[1];
    assign active0      = w_active[0];
    assign active1      = w_active[1];
    assign almost_full0 = w_almost_full[0];
    assign almost_full1 = w_almost_full[1];
    assign full0        = w_full[0];
    assign full1        = w_full[1];
    assign push_err0    = w_push_err[0];
    assign push_err1    = w_push_err[1];

endmodule

// File: doc/device1_tx.md
DEVICE1_TX -- requirements
Module: device1_tx

Interface
REQ-001 Parameters SHALL be: IDLE  8'hBC  idle/sync symbol; SYNC_SYMBOLS  4  idle symbols sent after reset before data; AF_TH  3  almost-full occupancy threshold.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be, one per line:
  clk  in  1  bit-rate clock; all state updates on rising edge
  reset  in  1  asynchronous reset, active-low
  push0, push1  in  1  write strobe, lane 0 / lane 1
  data_in0, data_in1  in  8  byte to enqueue, lane 0 / lane 1
  out0, out1  out  1  serial stream, MSB first, lane 0 / lane 1
  active0, active1  out  1  lane past sync phase, sending FIFO data or idle
  almost_full0, almost_full1  out  1  occupancy >= AF_TH
  full0, full1  out  1  occupancy == 4
  push_err0, push_err1  out  1  one-cycle pulse when a push is dropped

Function
REQ-004 The two lanes SHALL be identical and independent; lane x state SHALL NOT depend on lane y inputs.
REQ-005 Each lane SHALL contain a 4-entry x 8-bit FIFO with a 3-bit occupancy counter (0..4) and 2-bit wrapping read/write pointers.
REQ-006 Each lane SHALL contain an 8-bit shift register, a 3-bit bit counter, and a two-state FSM {SYNC, ACTIVE}.
REQ-007 outx SHALL equal the shift register MSB.
REQ-008 Symbol boundary: when bit counter == 7, the next edge SHALL load a new symbol and wrap the counter to 0; otherwise it SHALL shift left by one and increment the counter.
REQ-009 SYNC: each boundary SHALL load IDLE and increment the sync counter; at the boundary ending symbol SYNC_SYMBOLS the FSM SHALL go to ACTIVE.
REQ-010 The symbol loaded at the SYNC->ACTIVE boundary SHALL follow the ACTIVE load rule.
REQ-011 ACTIVE load rule: at a boundary, FIFO non-empty -> pop head and load it; FIFO empty -> load IDLE with no pop.
REQ-012 activex SHALL be 1 exactly while the FSM is ACTIVE.
REQ-013 Push accepted iff pushx=1, fullx=0 and data_inx != IDLE; an accepted byte SHALL be written at the write pointer on that edge.
REQ-014 Push with fullx=1 or data_inx == IDLE SHALL be dropped; push_errx SHALL be 1 for exactly the following cycle.
REQ-015 Full and empty SHALL be evaluated on pre-edge occupancy.
REQ-016 Push while full and a boundary pop on the same edge: push dropped, occupancy 4->3.
REQ-017 Push into an empty FIFO on a boundary edge: the boundary loads IDLE, and the byte is sent at the next boundary.
REQ-018 Accepted push plus pop on the same edge: occupancy unchanged, both pointers advance.
REQ-019 Pointers SHALL wrap 3->0; occupancy SHALL never exceed 4 or go below 0.
REQ-020 almost_fullx and fullx SHALL be decoded from the occupancy register only, with no input-to-output combinational path.
REQ-021 Minimum latency: a byte accepted into an empty FIFO in ACTIVE SHALL drive its MSB on outx at the next symbol boundary.

Reset
REQ-022 reset=0 SHALL immediately force: shift register=IDLE, bit counter=0, sync counter=0, FSM=SYNC, FIFO pointers/occupancy=0.
REQ-023 Output values during reset: outx=1 (IDLE MSB), activex=0, almost_fullx=0, fullx=0, push_errx=0.
REQ-024 Reset asserted mid-symbol or mid-operation SHALL discard FIFO contents and the partial symbol; after release the lane SHALL restart the sync phase.
REQ-025 FIFO storage contents SHALL need no reset.

Verification
REQ-026 Release reset, no pushes -> each outx repeats 1,0,1,1,1,1,0,0; activex rises at cycle 32 after release; idle continues.
REQ-027 Push 0x5A on lane 0 at cycle 0 after release -> out0 = 0,1,0,1,1,0,1,0 on cycles 32..39, then IDLE bits; out1 is idle only.
REQ-028 In SYNC, push 0x01,0x02,0x03,0x04,0x05 on consecutive cycles -> almost_full0 after the 3rd push, full0 after the 4th, 0x05 dropped with push_err0=1 for 1 cycle; stream sends 0x01..0x04 back-to-back, then IDLE.
REQ-029 Push data 0xBC in ACTIVE -> dropped, push_err=1 for 1 cycle, occupancy unchanged, stream stays IDLE.
REQ-030 With full FIFO, push on a boundary edge -> push dropped, push_err=1, occupancy=3.
REQ-031 Assert reset at bit 4 of a data symbol with 2 bytes queued -> outputs reset at once; after release 4 IDLE symbols are sent, and the queued bytes are never sent.
